// File: rtl/booth_radix4_mult.sv
// Iterative radix-4 Booth multiplier, two multiplier bits per clock.
// Valid/ready on both sides; signed or unsigned chosen per transaction.
module booth_radix4_mult #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int ITER = WIDTH / 2 + 1;
    localparam int EW   = WIDTH + 2;
    localparam int AW   = 2 * WIDTH + 4;
    localparam int CW   = $clog2(ITER);

    if ((WIDTH % 2) != 0 || WIDTH < 4 || WIDTH > 32) begin : g_bad_width
        $error("booth_radix4_mult: WIDTH must be even, 4..32");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [AW-1:0]       mc_q, mc_d;
    logic [EW-1:0]       mr_q, mr_d;
    logic                mr_prev_q, mr_prev_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]  prod_q, prod_d;
    logic [AW-1:0]       pp;
    logic                accept;
    logic                last;
    logic                sx_a;
    logic                sx_b;

    assign accept = in_valid && (state_q == IDLE);
    assign last   = (state_q == CALC) && (cnt_q == CW'(ITER - 1));
    assign sx_a   = signed_mode & a[WIDTH-1];
    assign sx_b   = signed_mode & b[WIDTH-1];

    // Recode the current 3-bit multiplier window into a partial product
    always_comb begin
        pp = '0;
        unique case ({mr_q[1:0], mr_prev_q})
            3'b001, 3'b010: pp = mc_q;
            3'b011:         pp = mc_q << 1;
            3'b100:         pp = -(mc_q << 1);
            3'b101, 3'b110: pp = -mc_q;
            default:        pp = '0;
        endcase
    end

    // Datapath next state: load on accept, one digit step per CALC cycle
    always_comb begin
        acc_d     = acc_q;
        mc_d      = mc_q;
        mr_d      = mr_q;
        mr_prev_d = mr_prev_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        if (accept) begin
            acc_d     = '0;
            mc_d      = {{(AW - WIDTH){sx_a}}, a};
            mr_d      = {{2{sx_b}}, b};
            mr_prev_d = 1'b0;
            cnt_d     = '0;
        end else if (state_q == CALC) begin
            acc_d     = acc_q + pp;
            mc_d      = mc_q << 2;
            mr_d      = {2'b00, mr_q[EW-1:2]};
            mr_prev_d = mr_q[1];
            cnt_d     = cnt_q + 1'b1;
            if (last) begin
                prod_d = acc_d[2*WIDTH-1:0];
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            mc_q      <= '0;
            mr_q      <= '0;
            mr_prev_q <= 1'b0;
            cnt_q     <= '0;
            prod_q    <= '0;
        end else begin
            acc_q     <= acc_d;
            mc_q      <= mc_d;
            mr_q      <= mr_d;
            mr_prev_q <= mr_prev_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = CALC;
            CALC:    if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = (state_q == DONE);
        product   = prod_q;
    end

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Bench for booth_radix4_mult: directed corners at WIDTH=8 and
// random streams at WIDTH 4/8/16/32 against a behavioural model.
module tb_booth_radix4_mult;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   ndone  = 0;

    always #5 clk = ~clk;

    task automatic chk(input int w, input string nm,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL w%0d %s actual=%0h required=%0h", w, nm, act, exp);
        end
    endtask

    // True product of w-bit operands, truncated to 2w bits
    function automatic logic [63:0] ref_mul(input logic [31:0] x,
                                            input logic [31:0] y,
                                            input bit sm, input int w);
        logic [63:0] tx, ty, r, mask;
        longint sx, sy;
        if (sm) begin
            tx = {32'b0, x} << (64 - w);
            ty = {32'b0, y} << (64 - w);
            sx = $signed(tx) >>> (64 - w);
            sy = $signed(ty) >>> (64 - w);
            r  = 64'(sx * sy);
        end else begin
            r = {32'b0, x} * {32'b0, y};
        end
        mask = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
        return r & mask;
    endfunction

    // ---------------- directed instance, WIDTH=8 ----------------
    logic        d_rst_n, d_iv, d_ir, d_sm, d_ov, d_or, d_busy;
    logic [7:0]  d_a, d_b;
    logic [15:0] d_p;

    booth_radix4_mult #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(d_rst_n), .in_valid(d_iv), .in_ready(d_ir),
        .a(d_a), .b(d_b), .signed_mode(d_sm), .out_valid(d_ov),
        .out_ready(d_or), .product(d_p), .busy(d_busy)
    );

    task automatic txn8(input logic [7:0] ta, input logic [7:0] tb2,
                        input bit sm, input logic [15:0] exp,
                        input string nm);
        @(posedge clk); #1;
        d_a = ta; d_b = tb2; d_sm = sm; d_iv = 1'b1; d_or = 1'b1;
        @(negedge clk);
        chk(8, {nm, "_in_ready"}, 64'(d_ir), 64'd1);
        @(posedge clk); #1;
        d_iv = 1'b0; d_a = ~ta; d_b = ~tb2; d_sm = ~sm;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk(8, {nm, "_lat"}, 64'(d_ov), 64'(k == 5));
        end
        chk(8, {nm, "_prod"}, 64'(d_p), 64'(exp));
        chk(8, {nm, "_model"}, ref_mul(32'(ta), 32'(tb2), sm, 8), 64'(exp));
        @(posedge clk);
        @(negedge clk);
        chk(8, {nm, "_handoff_ov"}, 64'(d_ov), 64'd0);
        chk(8, {nm, "_handoff_rdy"}, 64'(d_ir), 64'd1);
    endtask

    // ---------------- random streams at several widths ----------------
    for (genvar g = 0; g < 4; g++) begin : gr
        localparam int W  = (g == 0) ? 4 : (g == 1) ? 8 : (g == 2) ? 16 : 32;
        localparam int IT = W / 2 + 1;

        logic           iv, ir, sm, ov, orr, bsy;
        logic [W-1:0]   ra, rb;
        logic [2*W-1:0] p;

        booth_radix4_mult #(.WIDTH(W)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
            .a(ra), .b(rb), .signed_mode(sm), .out_valid(ov),
            .out_ready(orr), .product(p), .busy(bsy)
        );

        bit          m_busy = 1'b0;
        bit          m_ov   = 1'b0;
        int          m_cnt  = 0;
        int          m_acc  = 0;
        logic [63:0] m_exp  = '0;

        // Transaction-level model: accepted at edge t, result at t+IT,
        // held until taken by out_ready.
        always @(posedge clk) begin
            if (!rst_n) begin
                m_busy = 1'b0;
                m_ov   = 1'b0;
                m_cnt  = 0;
            end else if (!m_busy) begin
                if (iv) begin
                    m_busy = 1'b1;
                    m_cnt  = 0;
                    m_exp  = ref_mul(32'(ra), 32'(rb), sm, W);
                    m_acc++;
                end
            end else if (!m_ov) begin
                m_cnt++;
                if (m_cnt == IT) m_ov = 1'b1;
            end else if (orr) begin
                m_ov   = 1'b0;
                m_busy = 1'b0;
            end
        end

        always @(negedge clk) begin
            if (rst_n) begin
                chk(W, "in_ready", 64'(ir), 64'(!m_busy));
                chk(W, "busy", 64'(bsy), 64'(m_busy));
                chk(W, "out_valid", 64'(ov), 64'(m_ov));
                if (m_ov) chk(W, "product", 64'(p), m_exp);
            end
        end

        initial begin
            iv = 1'b0; ra = '0; rb = '0; sm = 1'b0; orr = 1'b0;
            @(posedge rst_n);
            for (int c = 0; c < 80000 && m_acc < 1000; c++) begin
                @(posedge clk); #1;
                iv  = ($urandom % 4) != 0;
                ra  = W'($urandom);
                rb  = W'($urandom);
                sm  = 1'($urandom % 2);
                orr = ($urandom % 4) != 0;
                if ($urandom % 8 == 0) ra = {1'b1, {(W - 1){1'b0}}};
                if ($urandom % 8 == 0) rb = {1'b1, {(W - 1){1'b0}}};
                if ($urandom % 16 == 0) ra = '0;
            end
            chk(W, "stream_count", 64'(m_acc >= 1000), 64'd1);
            iv = 1'b0; orr = 1'b1;
            repeat (IT + 4) @(posedge clk);
            ndone++;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0; d_rst_n = 1'b0;
        d_iv = 1'b0; d_a = '0; d_b = '0; d_sm = 1'b0; d_or = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(8, "rst_in_ready", 64'(d_ir), 64'd1);
        chk(8, "rst_out_valid", 64'(d_ov), 64'd0);
        chk(8, "rst_product", 64'(d_p), 64'd0);
        chk(8, "rst_busy", 64'(d_busy), 64'd0);
        rst_n = 1'b1; d_rst_n = 1'b1;

        txn8(8'h80, 8'h80, 1'b1, 16'h4000, "s_min_min");
        txn8(8'h7F, 8'h80, 1'b1, 16'hC080, "s_max_min");
        txn8(8'hFF, 8'h01, 1'b1, 16'hFFFF, "s_m1_1");
        txn8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_ff_ff");
        txn8(8'hFF, 8'h01, 1'b0, 16'h00FF, "u_ff_1");
        txn8(8'h00, 8'hA5, 1'b0, 16'h0000, "u_zero");

        // Backpressure with in_valid held high and operands changing
        @(posedge clk); #1;
        d_a = 8'h7F; d_b = 8'h80; d_sm = 1'b1; d_iv = 1'b1; d_or = 1'b0;
        @(posedge clk); #1;
        d_a = 8'h11; d_b = 8'h22; d_sm = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk(8, "bp_gate_rdy", 64'(d_ir), 64'd0);
            chk(8, "bp_lat", 64'(d_ov), 64'(k == 5));
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk(8, "bp_hold_ov", 64'(d_ov), 64'd1);
            chk(8, "bp_hold_prod", 64'(d_p), 64'hC080);
            chk(8, "bp_hold_rdy", 64'(d_ir), 64'd0);
        end
        @(posedge clk); #1;
        d_or = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk(8, "bp_release_ov", 64'(d_ov), 64'd0);
        chk(8, "bp_release_rdy", 64'(d_ir), 64'd1);
        chk(8, "bp_release_busy", 64'(d_busy), 64'd0);
        d_iv = 1'b0;

        // Reset in the middle of CALC
        @(posedge clk); #1;
        d_a = 8'h12; d_b = 8'h34; d_sm = 1'b0; d_iv = 1'b1; d_or = 1'b1;
        @(posedge clk); #1;
        d_iv = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        d_rst_n = 1'b0;
        #1;
        chk(8, "midrst_ov", 64'(d_ov), 64'd0);
        chk(8, "midrst_prod", 64'(d_p), 64'd0);
        chk(8, "midrst_rdy", 64'(d_ir), 64'd1);
        chk(8, "midrst_busy", 64'(d_busy), 64'd0);
        @(negedge clk);
        d_rst_n = 1'b1;
        txn8(8'h03, 8'hFB, 1'b1, 16'hFFF1, "post_rst");

        for (int c = 0; c < 90000 && ndone < 4; c++) @(posedge clk);
        chk(0, "streams_finished", 64'(ndone), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
